ram_rd_streamer: RTL and testbench

RAM_RD_STREAMER -- requirements
Module: ram_rd_streamer

---
 rtl/ram_prd_pkg.sv | 13 +
 rtl/ram_rd_streamer_if.sv | 30 +++
 rtl/rd_stream_fifo.sv | 44 ++++
 rtl/ram_rd_streamer.sv | 151 +++++++++++++++
 tb/tb_ram_rd_streamer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_prd_pkg.sv
// Shared types and default widths for the RAM read streamer.
package ram_prd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/ram_rd_streamer_if.sv
// Output stream of the RAM read streamer; o_par exists only when RAM_RD_STREAMER_PARITY_EN is defined.
interface ram_rd_streamer_if
  import ram_prd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_ready;
  logic              o_last;
`ifdef RAM_RD_STREAMER_PARITY_EN
  logic              o_par;
`endif

  modport master (
    input  o_ready,
    output o_data, o_valid, o_last
`ifdef RAM_RD_STREAMER_PARITY_EN
    , o_par
`endif
  );

  modport slave (
    output o_ready,
    input  o_data, o_valid, o_last
`ifdef RAM_RD_STREAMER_PARITY_EN
    , o_par
`endif
  );
endinterface

// File: rtl/rd_stream_fifo.sv
// Register-based FIFO with occupancy count; head is forced to zero when empty.
module rd_stream_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             pop;

  assign empty   = (count == '0);
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/ram_rd_streamer.sv
// Streams a burst of RAM reads into a valid/ready stream with credit-based issue.
// Optional o_par output and storage enabled by RAM_RD_STREAMER_PARITY_EN.
module ram_rd_streamer
  import ram_prd_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              RClk,
  input  logic              Rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] RA,
  output logic              RClk_En,
  input  logic [DATA_W-1:0] RD,
  output logic              busy,
  output logic              done,
  ram_rd_streamer_if.master s
);
  localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
`ifdef RAM_RD_STREAMER_PARITY_EN
  localparam int unsigned ENT_W = DATA_W + 1;
`else
  localparam int unsigned ENT_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   iss_left_q, iss_left_d;
  logic [ADDR_W:0]   out_left_q, out_left_d;
  logic [CNT_W-1:0]  inflight_q;
  logic [RD_LAT-1:0] vpipe_q;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_empty;
  logic              capture, pop, room_c, issue_c;
  logic [ENT_W-1:0]  wr_ent, head;

  assign capture = vpipe_q[RD_LAT-1];
  assign room_c  = (32'(inflight_q) + 32'(fifo_cnt)) < FIFO_D;
  assign pop     = s.o_valid && s.o_ready;
  assign RClk_En = issue_c;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  // Next state, read issue and burst bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    out_left_d = out_left_q;
    done_d     = 1'b0;
    issue_c    = 1'b0;
    RA         = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            issue_c    = 1'b1;
            RA         = base;
            addr_d     = base + ADDR_ONE;
            iss_left_d = len - LEN_ONE;
            out_left_d = len;
            state_d    = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        RA = addr_q;
        if ((iss_left_q != '0) && room_c) begin
          issue_c    = 1'b1;
          addr_d     = addr_q + ADDR_ONE;
          iss_left_d = iss_left_q - LEN_ONE;
        end
        if ((iss_left_q == '0) || (issue_c && (iss_left_q == LEN_ONE))) state_d = DRAIN;
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      out_left_d = out_left_q - LEN_ONE;
      if (s.o_last) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge RClk) begin
    if (Rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      iss_left_q <= '0;
      out_left_q <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      iss_left_q <= iss_left_d;
      out_left_q <= out_left_d;
      inflight_q <= inflight_q + CNT_W'(issue_c) - CNT_W'(capture);
      done_q     <= done_d;
    end
  end

  // Read-latency valid pipe: capture fires RD_LAT cycles after each issue.
  if (RD_LAT == 1) begin : g_pipe1
    always_ff @(posedge RClk) begin
      if (Rst) vpipe_q <= '0;
      else     vpipe_q <= issue_c;
    end
  end else begin : g_pipen
    always_ff @(posedge RClk) begin
      if (Rst) vpipe_q <= '0;
      else     vpipe_q <= {vpipe_q[RD_LAT-2:0], issue_c};
    end
  end

`ifdef RAM_RD_STREAMER_PARITY_EN
  assign wr_ent  = {^RD, RD};
  assign s.o_par = head[DATA_W];
`else
  assign wr_ent  = RD;
`endif

  rd_stream_fifo #(
    .DEPTH(FIFO_D),
    .WIDTH(ENT_W)
  ) u_fifo (
    .clk     (RClk),
    .rst     (Rst),
    .wr_en   (capture),
    .wr_data (wr_ent),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  assign s.o_data  = head[DATA_W-1:0];
  assign s.o_valid = !fifo_empty;
  assign s.o_last  = !fifo_empty && (out_left_q == LEN_ONE);
endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer with a latency-modelled RAM and a word scoreboard.
module tb_ram_rd_streamer;
  import ram_prd_pkg::*;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 4;
`ifdef RAM_RD_STREAMER_PARITY_EN
  localparam int unsigned RL = 1;
`else
  localparam int unsigned RL = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] ra;
  logic          rclk_en;
  logic [DW-1:0] rd;
  logic          busy;
  logic          done;

  ram_rd_streamer_if #(.DATA_W(DW)) s_if ();

  ram_rd_streamer #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .FIFO_D(FD)
  ) dut (
    .RClk(clk), .Rst(rst), .start(start), .base(base), .len(len),
    .RA(ra), .RClk_En(rclk_en), .RD(rd), .busy(busy), .done(done),
    .s(s_if.master)
  );

  always #5 clk = ~clk;

  // RAM model: data word equals its address, RL cycles after the address.
  logic [AW-1:0] a_pipe [RL];
  always @(posedge clk) begin
    a_pipe[0] <= ra;
    for (int i = 1; i < RL; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign rd = DW'(a_pipe[RL-1]);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] ra_log[$];
  int            checks = 0;
  int            errors = 0;
  int            n_issue = 0;
  int            n_done = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, hold-stability, done timing, issue log.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      exp_done   = 1'b0;
    end else begin
      if (rclk_en) begin
        n_issue++;
        ra_log.push_back(ra);
      end
      if (done) n_done++;
      if (done || exp_done) chk("done_timing", 32'(done), 32'(exp_done));
      if (prev_stall) chk("hold_data", 32'(s_if.o_data), 32'(prev_data));
      if (s_if.o_valid && s_if.o_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word_data", 32'(s_if.o_data), 32'(e.data));
          chk("word_last", 32'(s_if.o_last), 32'(e.last));
        end
`ifdef RAM_RD_STREAMER_PARITY_EN
        chk("word_par", 32'(s_if.o_par), 32'(^s_if.o_data));
`endif
      end
      exp_done   = (s_if.o_valid && s_if.o_ready && s_if.o_last) ||
                   (start && (len == '0) && !busy);
      prev_stall = s_if.o_valid && !s_if.o_ready;
      prev_data  = s_if.o_data;
    end
  end

  task automatic push_burst(input logic [AW-1:0] b, input int l);
    exp_t e;
    for (int k = 0; k < l; k++) begin
      e.data = DW'(AW'(32'(b) + k));
      e.last = (k == l - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] l);
    base  = b;
    len   = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
    cycles(2);
  endtask

  task automatic check_rst_vals(input string tag);
    @(negedge clk);
    chk({tag, "_ra"},     32'(ra),            32'd0);
    chk({tag, "_en"},     32'(rclk_en),       32'd0);
    chk({tag, "_valid"},  32'(s_if.o_valid),  32'd0);
    chk({tag, "_last"},   32'(s_if.o_last),   32'd0);
    chk({tag, "_busy"},   32'(busy),          32'd0);
    chk({tag, "_done"},   32'(done),          32'd0);
    chk({tag, "_data"},   32'(s_if.o_data),   32'd0);
  endtask

  initial begin
    int lat;
    int nv;
    int i0;
    int d0;
    s_if.o_ready = 1'b0;
    cycles(3);
    rst = 1'b0;
    check_rst_vals("rst0");

    // Burst 0..7 with ready high: latency, back-to-back words, single done.
    cycles(1);
    s_if.o_ready = 1'b1;
    d0 = n_done;
    push_burst(9'd0, 8);
    pulse_start(9'd0, 10'd8);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_if.o_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("start_to_valid", 32'(lat), 32'(RL + 1));
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (s_if.o_valid) nv++;
      if (i < 7) @(negedge clk);
    end
    chk("throughput", 32'(nv), 32'd8);
    wait_idle();
    chk("burst8_done", 32'(n_done - d0), 32'd1);
    chk("burst8_sb", 32'(exp_q.size()), 32'd0);

    // Address wrap 510, 511, 0, 1.
    ra_log.delete();
    push_burst(9'd510, 4);
    pulse_start(9'd510, 10'd4);
    wait_idle();
    chk("wrap_n", 32'(ra_log.size()), 32'd4);
    if (ra_log.size() == 4) begin
      chk("wrap_ra0", 32'(ra_log[0]), 32'd510);
      chk("wrap_ra1", 32'(ra_log[1]), 32'd511);
      chk("wrap_ra2", 32'(ra_log[2]), 32'd0);
      chk("wrap_ra3", 32'(ra_log[3]), 32'd1);
    end
    chk("wrap_sb", 32'(exp_q.size()), 32'd0);

    // Backpressure: ten stalled cycles cap issue at FIFO depth.
    s_if.o_ready = 1'b0;
    i0 = n_issue;
    push_burst(9'd40, 16);
    pulse_start(9'd40, 10'd16);
    cycles(9);
    @(negedge clk);
    chk("stall_issued", 32'(n_issue - i0), 32'(FD));
    chk("stall_valid", 32'(s_if.o_valid), 32'd1);
    chk("stall_head", 32'(s_if.o_data), 32'd40);
    @(posedge clk); #1;
    s_if.o_ready = 1'b1;
    wait_idle();
    chk("stall_total", 32'(n_issue - i0), 32'd16);
    chk("stall_sb", 32'(exp_q.size()), 32'd0);

    // Zero-length start: done next cycle, nothing issued.
    i0 = n_issue;
    pulse_start(9'd5, 10'd0);
    @(negedge clk);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_issue", 32'(n_issue - i0), 32'd0);
    cycles(2);

    // A second start during a burst is ignored.
    i0 = n_issue;
    d0 = n_done;
    push_burst(9'd32, 10);
    pulse_start(9'd32, 10'd10);
    cycles(3);
    pulse_start(9'd256, 10'd5);
    wait_idle();
    chk("ignore_issue", 32'(n_issue - i0), 32'd10);
    chk("ignore_done", 32'(n_done - d0), 32'd1);
    chk("ignore_sb", 32'(exp_q.size()), 32'd0);

    // Reset at cycle 5 of a 32-word burst.
    d0 = n_done;
    push_burst(9'd100, 32);
    pulse_start(9'd100, 10'd32);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    check_rst_vals("midrst");
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (s_if.o_valid) nv++;
    end
    chk("midrst_nodata", 32'(nv), 32'd0);
    chk("midrst_nodone", 32'(n_done - d0), 32'd0);

    // Mixed ready pattern on a fresh burst after reset.
    push_burst(9'd300, 12);
    pulse_start(9'd300, 10'd12);
    for (int i = 0; i < 40 && busy; i++) begin
      s_if.o_ready = ((i % 3) != 1);
      cycles(1);
    end
    s_if.o_ready = 1'b1;
    wait_idle();
    chk("mixed_sb", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
